// File: rtl/psg_pkg.sv
// Shared constants, types and helpers for the PSG voice datapath.
package psg_pkg;

   localparam int unsigned ACC_WID       = 24;
   localparam int unsigned LFSR_WID      = 23;
   localparam int unsigned LFSR_TAP_HI   = 22;
   localparam int unsigned LFSR_TAP_LO   = 17;
   localparam int unsigned NOISE_CLK_BIT = 19;
   localparam int unsigned PW_WID        = 12;

   localparam logic [LFSR_WID-1:0] LFSR_SEED = 23'h7FFFF8;

   typedef logic [ACC_WID-1:0]  acc_t;
   typedef logic [LFSR_WID-1:0] lfsr_t;

   // Accumulator update selected each clk, highest priority first: CLEAR, SYNC, ADD, HOLD.
   typedef enum logic [1:0] {
      ACC_HOLD  = 2'd0,
      ACC_ADD   = 2'd1,
      ACC_SYNC  = 2'd2,
      ACC_CLEAR = 2'd3
   } acc_op_t;

   function automatic logic lfsr_fb(input lfsr_t v);
      return v[LFSR_TAP_HI] ^ v[LFSR_TAP_LO];
   endfunction

endpackage

// File: rtl/psg_noise_lfsr.sv
// 23-bit Fibonacci noise LFSR with reseed input and an all-zero lock-up guard.
module psg_noise_lfsr
   import psg_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        reseed,
   input  logic        step,
   output logic [22:0] lfsr
);

   lfsr_t r_lfsr;

   // A zero state would never leave zero, so it is forced back to the seed.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_lfsr <= LFSR_SEED;
      end else if (reseed || (r_lfsr == '0)) begin
         r_lfsr <= LFSR_SEED;
      end else if (step) begin
         r_lfsr <= {r_lfsr[LFSR_WID-2:0], lfsr_fb(r_lfsr)};
      end
   end

   assign lfsr = r_lfsr;

endmodule

// File: rtl/psg_tone_generator.sv
// PSG per-voice waveform source: phase accumulator feeding triangle, saw, pulse, noise and wavetable outputs.
// Optional ring modulation of the triangle is enabled by defining PSG_RINGMOD_EN.
module psg_tone_generator #(
   parameter int unsigned WID     = 16,
   parameter int unsigned ACC_WID = psg_pkg::ACC_WID,
   parameter int unsigned WT_AW   = 10
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               ce,
   input  logic [ACC_WID-1:0] freq,
   input  logic [11:0]        pw,
   input  logic               test,
   input  logic               sync_en,
   input  logic               sync_in,
`ifdef PSG_RINGMOD_EN
   input  logic               ring_en,
   input  logic               ring_in,
`endif
   output logic               acc_msb_o,
   output logic [WID-1:0]     tri_o,
   output logic [WID-1:0]     saw_o,
   output logic [WID-1:0]     pulse_o,
   output logic [WID-1:0]     noise_o,
   output logic [WID-1:0]     wave_o,
   output logic [WT_AW-1:0]   wt_adr_o,
   input  logic [WID-1:0]     wt_dat_i
);

   import psg_pkg::*;

   acc_t        r_acc;
   logic        r_sync_prev;
   acc_t        w_acc_next;
   acc_op_t     w_acc_op;
   logic        w_sync_edge;
   logic        w_lfsr_step;
   logic [22:0] w_lfsr;
   logic        w_tri_inv;
   logic        w_pulse_hi;
   logic        w_unused_lfsr;

   // Accumulator update: test beats a sync edge, which beats a normal advance.
   always_comb begin
      w_sync_edge = ce & sync_en & sync_in & ~r_sync_prev;
      w_acc_op    = ACC_HOLD;
      w_acc_next  = r_acc;
      if (test) begin
         w_acc_op = ACC_CLEAR;
      end else if (w_sync_edge) begin
         w_acc_op = ACC_SYNC;
      end else if (ce) begin
         w_acc_op = ACC_ADD;
      end
      case (w_acc_op)
         ACC_CLEAR, ACC_SYNC: w_acc_next = '0;
         ACC_ADD:             w_acc_next = r_acc + freq;
         default:             w_acc_next = r_acc;
      endcase
      w_lfsr_step = (w_acc_op == ACC_ADD) & ~r_acc[NOISE_CLK_BIT] & w_acc_next[NOISE_CLK_BIT];
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_acc       <= '0;
         r_sync_prev <= 1'b0;
      end else begin
         r_acc <= w_acc_next;
         if (ce) begin
            r_sync_prev <= sync_in;
         end
      end
   end

   psg_noise_lfsr u_lfsr (
      .clk    (clk),
      .rst    (rst),
      .reseed (test),
      .step   (w_lfsr_step),
      .lfsr   (w_lfsr)
   );

`ifdef PSG_RINGMOD_EN
   assign w_tri_inv = r_acc[ACC_WID-1] ^ (ring_en & ring_in);
`else
   assign w_tri_inv = r_acc[ACC_WID-1];
`endif

   assign w_pulse_hi    = (r_acc[ACC_WID-1 -: PW_WID] >= pw);
   assign w_unused_lfsr = ^w_lfsr;

   // Waveforms register from the current state; wave_o adds one more stage behind the RAM read.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         acc_msb_o <= 1'b0;
         saw_o     <= '0;
         tri_o     <= '0;
         pulse_o   <= '0;
         noise_o   <= '0;
         wt_adr_o  <= '0;
         wave_o    <= '0;
      end else begin
         acc_msb_o <= r_acc[ACC_WID-1];
         saw_o     <= r_acc[ACC_WID-1 -: WID];
         tri_o     <= {WID{w_tri_inv}} ^ r_acc[ACC_WID-2 -: WID];
         pulse_o   <= {WID{w_pulse_hi}};
         noise_o   <= w_lfsr[LFSR_WID-1 -: WID];
         wt_adr_o  <= r_acc[ACC_WID-1 -: WT_AW];
         wave_o    <= wt_dat_i;
      end
   end

endmodule
